// File: rtl/ddr_ctrl_pkg.sv
// Shared types and constants for the DDR3 controller front end.
package ddr_ctrl_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 64;
    localparam int ROW_W  = 14;
    localparam int BANK_W = 3;
    localparam int COL_W  = 10;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        RD_WAIT,
        RESP
    } fe_state_t;

    typedef struct packed {
        logic              cmd;
        logic [ROW_W-1:0]  row;
        logic [BANK_W-1:0] bank;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Flat address layout is {row, bank, col}, so decode is pure bit slicing.
    function automatic req_t decode_req(input logic cmd,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
        req_t r;
        r.cmd   = cmd;
        r.row   = addr[ADDR_W-1 -: ROW_W];
        r.bank  = addr[COL_W +: BANK_W];
        r.col   = addr[COL_W-1:0];
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/cpu_req_frontend_if.sv
// CPU-side and scheduler-side bus signals of the controller front end.
interface cpu_req_frontend_if;
    import ddr_ctrl_pkg::*;

    logic              i_cpu_cmd;
    logic              i_cpu_valid;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wr_data;
    logic              o_cpu_data_rdy;
    logic              o_cpu_rd_data_valid;
    logic [DATA_W-1:0] o_cpu_rd_data;
    logic              i_init_done;
    logic              o_req_valid;
    logic              i_req_ready;
    logic              o_req_cmd;
    logic [ROW_W-1:0]  o_req_row;
    logic [BANK_W-1:0] o_req_bank;
    logic [COL_W-1:0]  o_req_col;
    logic [DATA_W-1:0] o_req_wdata;
    logic              i_rdata_valid;
    logic [DATA_W-1:0] i_rdata;
    logic              o_timeout;

    modport slave (
        input  i_cpu_cmd, i_cpu_valid, i_cpu_addr, i_cpu_wr_data,
        input  i_init_done, i_req_ready, i_rdata_valid, i_rdata,
        output o_cpu_data_rdy, o_cpu_rd_data_valid, o_cpu_rd_data,
        output o_req_valid, o_req_cmd, o_req_row, o_req_bank, o_req_col, o_req_wdata,
        output o_timeout
    );

    modport master (
        output i_cpu_cmd, i_cpu_valid, i_cpu_addr, i_cpu_wr_data,
        output i_init_done, i_req_ready, i_rdata_valid, i_rdata,
        input  o_cpu_data_rdy, o_cpu_rd_data_valid, o_cpu_rd_data,
        input  o_req_valid, o_req_cmd, o_req_row, o_req_bank, o_req_col, o_req_wdata,
        input  o_timeout
    );

endinterface

// File: rtl/cpu_req_frontend_counter.sv
// Saturating cycle counter; held at zero while disabled, done at MAX_COUNT-1.
module cpu_req_frontend_counter #(
    parameter int MAX_COUNT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic done
);

    localparam int CNT_W = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = en && (count == LAST);

endmodule

// File: rtl/cpu_req_frontend.sv
// CPU request front end: holds one request, hands it to the scheduler,
// returns read data and flags reads that never come back.
module cpu_req_frontend
    import ddr_ctrl_pkg::*;
#(
    parameter int RD_TIMEOUT = 1024
) (
    input logic                i_cpu_ck,
    input logic                i_cpu_reset_n,
    input logic                i_cpu_reset,
    cpu_req_frontend_if.slave  bus
);

    if (ROW_W + BANK_W + COL_W != ADDR_W) begin : g_width_check
        $error("cpu_req_frontend: row/bank/col widths do not sum to ADDR_W");
    end

    fe_state_t         state;
    fe_state_t         state_next;
    req_t              hold;
    logic [DATA_W-1:0] rd_data;
    logic              timeout;
    logic              timer_done;
    logic              rd_expired;

    cpu_req_frontend_counter #(
        .MAX_COUNT (RD_TIMEOUT)
    ) u_rd_timer (
        .clk   (i_cpu_ck),
        .rst_n (i_cpu_reset_n),
        .en    (state == RD_WAIT),
        .done  (timer_done)
    );

    // Returned data takes priority over an expiry landing in the same cycle.
    assign rd_expired = (state == RD_WAIT) && !bus.i_rdata_valid && timer_done;

    always_ff @(posedge i_cpu_ck or negedge i_cpu_reset_n) begin
        if (!i_cpu_reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (bus.i_init_done) state_next = IDLE;
            IDLE:    if (bus.i_cpu_valid) state_next = ISSUE;
            ISSUE:   if (bus.i_req_ready) state_next = (hold.cmd == CMD_WRITE) ? IDLE : RD_WAIT;
            RD_WAIT: begin
                if (bus.i_rdata_valid) begin
                    state_next = RESP;
                end else if (timer_done) begin
                    state_next = IDLE;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = INIT;
        endcase
        if (i_cpu_reset) begin
            state_next = INIT;
        end
    end

    // Soft reset clears the request and error flag but leaves the last read data visible.
    always_ff @(posedge i_cpu_ck or negedge i_cpu_reset_n) begin
        if (!i_cpu_reset_n) begin
            hold    <= '0;
            rd_data <= '0;
            timeout <= 1'b0;
        end else if (i_cpu_reset) begin
            hold    <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && bus.i_cpu_valid) begin
                hold <= decode_req(bus.i_cpu_cmd, bus.i_cpu_addr, bus.i_cpu_wr_data);
            end
            if (state == RD_WAIT && bus.i_rdata_valid) begin
                rd_data <= bus.i_rdata;
            end
            if (rd_expired) begin
                timeout <= 1'b1;
            end
        end
    end

    assign bus.o_cpu_data_rdy      = (state == IDLE);
    assign bus.o_cpu_rd_data_valid = (state == RESP);
    assign bus.o_cpu_rd_data       = rd_data;
    assign bus.o_req_valid         = (state == ISSUE);
    assign bus.o_req_cmd           = hold.cmd;
    assign bus.o_req_row           = hold.row;
    assign bus.o_req_bank          = hold.bank;
    assign bus.o_req_col           = hold.col;
    assign bus.o_req_wdata         = hold.wdata;
    assign bus.o_timeout           = timeout;

endmodule

// File: tb/tb_cpu_req_frontend.sv
// Directed and randomized bench for cpu_req_frontend with a CPU-side memory model
// and a scheduler model that stores writes by decoded row/bank/col.
`timescale 1ns/1ps
module tb_cpu_req_frontend;

    localparam int TB_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic soft_rst;

    int vectors = 0;
    int miscompares = 0;
    int hs_count = 0;
    int rise_count = 0;
    int exp_hs = 0;
    int exp_rise = 0;
    logic exp_timeout = 1'b0;
    logic req_valid_d = 1'b0;

    logic [63:0] ref_mem [int];
    logic [63:0] sched_mem [int];
    logic [26:0] addr_q [$];

    always #5 clk = ~clk;

    cpu_req_frontend_if bus ();

    cpu_req_frontend #(
        .RD_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .i_cpu_ck      (clk),
        .i_cpu_reset_n (rst_n),
        .i_cpu_reset   (soft_rst),
        .bus           (bus.slave)
    );

    // Count scheduler handshakes and distinct request assertions.
    always @(negedge clk) begin
        if (bus.o_req_valid === 1'b1 && bus.i_req_ready === 1'b1) hs_count <= hs_count + 1;
        if (bus.o_req_valid === 1'b1 && !req_valid_d) rise_count <= rise_count + 1;
        req_valid_d <= (bus.o_req_valid === 1'b1);
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [13:0] f_row(input logic [26:0] a);
        return 14'(a / 27'd8192);
    endfunction
    function automatic logic [2:0] f_bank(input logic [26:0] a);
        return 3'((a / 27'd1024) % 27'd8);
    endfunction
    function automatic logic [9:0] f_col(input logic [26:0] a);
        return 10'(a % 27'd1024);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random CPU traffic while the front end is busy; never strobes while rdy is visible.
    task automatic busy_junk();
        bus.i_cpu_valid   = (bus.o_cpu_data_rdy === 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.i_cpu_cmd     = 1'($urandom_range(0, 1));
        bus.i_cpu_addr    = 27'($urandom);
        bus.i_cpu_wr_data = {$urandom, $urandom};
    endtask

    task automatic cpu_access(input string tag, input logic cmd, input logic [26:0] addr,
                              input logic [63:0] wdata, input int ready_lat,
                              input int data_lat, input logic [63:0] exp_rd);
        int guard;
        int key;
        logic [63:0] prev_rd;
        guard = 0;
        while (bus.o_cpu_data_rdy !== 1'b1 && guard < 64) begin
            busy_junk();
            tick();
            guard++;
        end
        if (guard == 64) begin
            check({tag, "/rdy_wait"}, bus.o_cpu_data_rdy, 64'd1);
            return;
        end
        prev_rd = bus.o_cpu_rd_data;
        bus.i_cpu_valid   = 1'b1;
        bus.i_cpu_cmd     = cmd;
        bus.i_cpu_addr    = addr;
        bus.i_cpu_wr_data = wdata;
        tick();
        busy_junk();
        exp_rise++;
        check({tag, "/rdy_low"}, bus.o_cpu_data_rdy, 64'd0);
        check({tag, "/req_valid"}, bus.o_req_valid, 64'd1);
        check({tag, "/cmd"}, bus.o_req_cmd, 64'(cmd));
        check({tag, "/row"}, bus.o_req_row, 64'(f_row(addr)));
        check({tag, "/bank"}, bus.o_req_bank, 64'(f_bank(addr)));
        check({tag, "/col"}, bus.o_req_col, 64'(f_col(addr)));
        check({tag, "/wdata"}, bus.o_req_wdata, wdata);
        check({tag, "/timeout"}, bus.o_timeout, 64'(exp_timeout));
        for (int i = 0; i < ready_lat; i++) begin
            bus.i_rdata_valid = 1'($urandom_range(0, 1));
            bus.i_rdata       = {$urandom, $urandom};
            tick();
            busy_junk();
            check({tag, "/req_hold"}, bus.o_req_valid, 64'd1);
            check({tag, "/row_hold"}, bus.o_req_row, 64'(f_row(addr)));
            check({tag, "/rd_data_keep"}, bus.o_cpu_rd_data, prev_rd);
        end
        bus.i_rdata_valid = 1'b0;
        key = int'({bus.o_req_row, bus.o_req_bank, bus.o_req_col});
        if (cmd) sched_mem[key] = bus.o_req_wdata;
        bus.i_req_ready = 1'b1;
        tick();
        busy_junk();
        bus.i_req_ready = 1'b0;
        exp_hs++;
        check({tag, "/req_drop"}, bus.o_req_valid, 64'd0);
        if (cmd) begin
            check({tag, "/wr_rdy_back"}, bus.o_cpu_data_rdy, 64'd1);
            return;
        end
        if (data_lat < 0) begin
            for (int k = 1; k < TB_TIMEOUT; k++) begin
                tick();
                busy_junk();
                check({tag, "/to_early"}, bus.o_timeout, 64'(exp_timeout));
                check({tag, "/to_rdy"}, bus.o_cpu_data_rdy, 64'd0);
            end
            tick();
            busy_junk();
            exp_timeout = 1'b1;
            check({tag, "/to_set"}, bus.o_timeout, 64'd1);
            check({tag, "/to_rdy_back"}, bus.o_cpu_data_rdy, 64'd1);
            check({tag, "/to_no_valid"}, bus.o_cpu_rd_data_valid, 64'd0);
            check({tag, "/to_rd_keep"}, bus.o_cpu_rd_data, prev_rd);
            return;
        end
        for (int i = 0; i < data_lat; i++) begin
            tick();
            busy_junk();
            check({tag, "/no_rd_valid"}, bus.o_cpu_rd_data_valid, 64'd0);
        end
        bus.i_rdata_valid = 1'b1;
        bus.i_rdata = sched_mem.exists(key) ? sched_mem[key] : 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        busy_junk();
        bus.i_rdata_valid = 1'b0;
        bus.i_rdata       = {$urandom, $urandom};
        check({tag, "/rd_valid"}, bus.o_cpu_rd_data_valid, 64'd1);
        check({tag, "/rd_data"}, bus.o_cpu_rd_data, exp_rd);
        check({tag, "/rd_rdy_low"}, bus.o_cpu_data_rdy, 64'd0);
        check({tag, "/rd_timeout"}, bus.o_timeout, 64'(exp_timeout));
        tick();
        busy_junk();
        check({tag, "/rd_valid_1cyc"}, bus.o_cpu_rd_data_valid, 64'd0);
        check({tag, "/rd_rdy_back"}, bus.o_cpu_data_rdy, 64'd1);
        check({tag, "/rd_data_hold"}, bus.o_cpu_rd_data, exp_rd);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/rdy"}, bus.o_cpu_data_rdy, 64'd0);
        check({tag, "/rd_valid"}, bus.o_cpu_rd_data_valid, 64'd0);
        check({tag, "/rd_data"}, bus.o_cpu_rd_data, 64'd0);
        check({tag, "/req_valid"}, bus.o_req_valid, 64'd0);
        check({tag, "/req_fields"}, {bus.o_req_cmd, bus.o_req_row, bus.o_req_bank, bus.o_req_col}, 64'd0);
        check({tag, "/wdata"}, bus.o_req_wdata, 64'd0);
        check({tag, "/timeout"}, bus.o_timeout, 64'd0);
    endtask

    initial begin
        logic [26:0] a;
        logic [63:0] d;
        logic [63:0] last_rd;
        rst_n = 1'b0;
        soft_rst = 1'b0;
        bus.i_cpu_cmd = 1'b0;
        bus.i_cpu_valid = 1'b0;
        bus.i_cpu_addr = '0;
        bus.i_cpu_wr_data = '0;
        bus.i_init_done = 1'b0;
        bus.i_req_ready = 1'b0;
        bus.i_rdata_valid = 1'b0;
        bus.i_rdata = '0;
        $display("[TB] reset and init");
        repeat (3) tick();
        check_all_zero("async_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("init_rdy_low", bus.o_cpu_data_rdy, 64'd0);
        end
        bus.i_init_done = 1'b1;
        check("init_rdy_same_cycle", bus.o_cpu_data_rdy, 64'd0);
        tick();
        check("init_rdy_high", bus.o_cpu_data_rdy, 64'd1);
        check("init_req_valid", bus.o_req_valid, 64'd0);
        check("init_timeout", bus.o_timeout, 64'd0);

        $display("[TB] directed write and reads");
        cpu_access("wr_5a", 1'b1, 27'h5A_5A5A, 64'hDEADBEEF_CAFEF00D, 0, 0, 64'd0);
        ref_mem[int'(27'h5A_5A5A)] = 64'hDEADBEEF_CAFEF00D;
        sched_mem[int'(27'h123_4567)] = 64'h0123_4567_89AB_CDEF;
        cpu_access("rd_delay", 1'b0, 27'h123_4567, 64'd0, 3, 5, 64'h0123_4567_89AB_CDEF);
        cpu_access("rd_edge", 1'b0, 27'h5A_5A5A, 64'd0, 2, TB_TIMEOUT - 1, 64'hDEADBEEF_CAFEF00D);
        check("edge_no_timeout", bus.o_timeout, 64'd0);

        $display("[TB] read timeout and soft reset");
        cpu_access("rd_timeout", 1'b0, 27'h7FF_FFFF, 64'd0, 1, -1, 64'd0);
        repeat (5) tick();
        check("timeout_sticky", bus.o_timeout, 64'd1);
        cpu_access("wr_after_to", 1'b1, 27'h000_0400, 64'h1111_2222_3333_4444, 0, 0, 64'd0);
        ref_mem[int'(27'h000_0400)] = 64'h1111_2222_3333_4444;
        last_rd = 64'hDEADBEEF_CAFEF00D;
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        exp_timeout = 1'b0;
        check("soft_timeout_clr", bus.o_timeout, 64'd0);
        check("soft_rdy_low", bus.o_cpu_data_rdy, 64'd0);
        check("soft_rd_keep", bus.o_cpu_rd_data, last_rd);
        check("soft_hold_clr", bus.o_req_wdata, 64'd0);
        tick();
        check("soft_rdy_back", bus.o_cpu_data_rdy, 64'd1);

        $display("[TB] soft reset during issue");
        bus.i_cpu_valid = 1'b1;
        bus.i_cpu_cmd = 1'b0;
        bus.i_cpu_addr = 27'h2AB_CDEF;
        tick();
        bus.i_cpu_valid = 1'b0;
        exp_rise++;
        check("abort_req_valid", bus.o_req_valid, 64'd1);
        tick();
        check("abort_req_hold", bus.o_req_valid, 64'd1);
        soft_rst = 1'b1;
        bus.i_init_done = 1'b0;
        tick();
        soft_rst = 1'b0;
        check("abort_req_drop", bus.o_req_valid, 64'd0);
        check("abort_fields_clr", {bus.o_req_row, bus.o_req_bank, bus.o_req_col}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            busy_junk();
            tick();
            check("abort_rdy_low", bus.o_cpu_data_rdy, 64'd0);
            check("abort_no_req", bus.o_req_valid, 64'd0);
        end
        bus.i_cpu_valid = 1'b0;
        bus.i_init_done = 1'b1;
        tick();
        check("abort_rdy_back", bus.o_cpu_data_rdy, 64'd1);

        $display("[TB] random write/read loop");
        for (int n = 0; n < 100; n++) begin
            a = 27'($urandom);
            d = {$urandom, $urandom};
            cpu_access("rnd_wr", 1'b1, a, d, int'($urandom_range(0, 20)), 0, 64'd0);
            ref_mem[int'(a)] = d;
            addr_q.push_back(a);
            if ($urandom_range(0, 1) == 0) a = addr_q[$urandom_range(0, addr_q.size() - 1)];
            cpu_access("rnd_rd", 1'b0, a, 64'd0, int'($urandom_range(0, 20)),
                       int'($urandom_range(0, TB_TIMEOUT - 1)), ref_mem[int'(a)]);
        end
        bus.i_cpu_valid = 1'b0;
        repeat (2) tick();
        check("handshake_count", 64'(hs_count), 64'(exp_hs));
        check("request_count", 64'(rise_count), 64'(exp_rise));
        check("final_timeout", bus.o_timeout, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
